font_rom_scheduler: RTL

//  Shares the single synchronous font ROM among NUM_REQ text-field requesters (date, time, timer, labels, symbol).

---
 rtl/font_rom_scheduler.sv | 118 +++++++++++
 1 files changed

// File: rtl/font_rom_scheduler.sv
// Shares one synchronous font ROM among prioritised text-field requesters and
// produces registered VGA pixel colour, with a frame-based blink for edited fields.
module font_rom_scheduler #(
    parameter int NUM_REQ      = 8,
    parameter int ROM_LAT      = 1,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 i_video_on,
    input  logic                 i_frame_tick,
    input  logic [NUM_REQ-1:0]   i_req_on,
    input  logic [7*NUM_REQ-1:0] i_req_char,
    input  logic [4*NUM_REQ-1:0] i_req_row,
    input  logic [3*NUM_REQ-1:0] i_req_bit,
    input  logic [3*NUM_REQ-1:0] i_req_color,
    input  logic [NUM_REQ-1:0]   i_edit_sel,
    output logic [10:0]          o_rom_addr,
    input  logic [7:0]           i_rom_data,
    output logic [2:0]           o_graph_rgb,
    output logic [NUM_REQ-1:0]   o_grant,
    output logic                 o_conflict,
    output logic                 o_blink_phase
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    // Side-info word: {bit, color, hit, blank, conflict, grant}
    localparam int SW = 9 + NUM_REQ;

    logic [IW-1:0]      w_win;
    logic               w_hit;
    logic               w_multi;
    logic [NUM_REQ-1:0] w_grant;
    logic [6:0]         w_char;
    logic [3:0]         w_row;
    logic [2:0]         w_bit;
    logic [2:0]         w_color;
    logic               w_blank;

    logic [10:0]        r_rom_addr;
    logic [SW-1:0]      r_side [0:ROM_LAT];
    logic [2:0]         r_graph_rgb;
    logic [NUM_REQ-1:0] r_grant;
    logic               r_conflict;
    logic [CW-1:0]      r_blink_cnt;
    logic               r_blink_phase;

    logic [2:0]         w_d_bit;
    logic [2:0]         w_d_color;
    logic               w_d_hit;
    logic               w_d_blank;
    logic               w_d_conflict;
    logic [NUM_REQ-1:0] w_d_grant;
    logic               w_lit;

    always_comb begin
        w_win = '0;
        // Descending scan so the lowest requesting index is the last write.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (i_req_on[i]) w_win = IW'(i);
        end
        w_hit   = (|i_req_on) & i_video_on;
        w_multi = i_video_on & ((i_req_on & (i_req_on - NUM_REQ'(1))) != '0);
        w_grant = w_hit ? (NUM_REQ'(1) << w_win) : '0;
        w_char  = i_req_char[w_win*7 +: 7];
        w_row   = i_req_row[w_win*4 +: 4];
        w_bit   = i_req_bit[w_win*3 +: 3];
        w_color = i_req_color[w_win*3 +: 3];
        w_blank = i_edit_sel[w_win] & r_blink_phase;
    end

    assign w_d_grant    = r_side[ROM_LAT][NUM_REQ-1:0];
    assign w_d_conflict = r_side[ROM_LAT][NUM_REQ];
    assign w_d_blank    = r_side[ROM_LAT][NUM_REQ+1];
    assign w_d_hit      = r_side[ROM_LAT][NUM_REQ+2];
    assign w_d_color    = r_side[ROM_LAT][NUM_REQ+5:NUM_REQ+3];
    assign w_d_bit      = r_side[ROM_LAT][NUM_REQ+8:NUM_REQ+6];
    assign w_lit        = i_rom_data[3'd7 - w_d_bit];

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_rom_addr  <= '0;
            for (int k = 0; k <= ROM_LAT; k++) r_side[k] <= '0;
            r_graph_rgb <= '0;
            r_grant     <= '0;
            r_conflict  <= 1'b0;
        end else begin
            r_rom_addr <= w_hit ? {w_char, w_row} : 11'h000;
            r_side[0]  <= {w_bit, w_color, w_hit, w_blank, w_multi, w_grant};
            for (int k = 1; k <= ROM_LAT; k++) r_side[k] <= r_side[k-1];
            r_graph_rgb <= (w_d_hit && !w_d_blank && w_lit) ? w_d_color : 3'b000;
            r_grant     <= w_d_grant;
            r_conflict  <= w_d_conflict;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (i_frame_tick) begin
            if (r_blink_cnt == CW'(BLINK_FRAMES - 1)) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + CW'(1);
            end
        end
    end

    assign o_rom_addr    = r_rom_addr;
    assign o_graph_rgb   = r_graph_rgb;
    assign o_grant       = r_grant;
    assign o_conflict    = r_conflict;
    assign o_blink_phase = r_blink_phase;

endmodule
